// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one sequential ALU among NREQ requesters,
// with a WAIT-state watchdog and first-cycle blanking of a stale ALU done.
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int TIMEOUT = 63,
  localparam int OW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_opA,
  input  logic [16*NREQ-1:0]   req_opB,
  input  logic [2*NREQ-1:0]    req_opcode,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_res,
  output logic                 rsp_err,
  output logic [15:0]          alu_opA,
  output logic [15:0]          alu_opB,
  output logic [1:0]           alu_opcode,
  output logic                 alu_en,
  input  logic [31:0]          alu_res,
  input  logic                 alu_done,
  output logic                 busy,
  output logic [OW-1:0]        owner
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  state_t r_state, w_nxt;
  logic [OW-1:0] r_ptr, r_owner, w_sel;
  logic [7:0] r_cnt;
  logic [NREQ-1:0] w_hi, w_hi_oh, w_lo_oh, w_oh, r_ack, r_rsp_valid;
  logic [OW-1:0][NREQ-1:0] w_bit;
  logic [31:0] r_res;
  logic [15:0] r_opa, r_opb;
  logic [1:0] r_opc;
  logic r_err, r_en, r_busy, w_any, w_done, w_to;
  // Requests above ptr take priority; otherwise wrap to the lowest pending one.
  for (genvar g = 0; g < NREQ; g++) begin : g_hi
    assign w_hi[g] = req[g] & (OW'(g) > r_ptr);
  end
  assign w_hi_oh = w_hi & (~w_hi + NREQ'(1));
  assign w_lo_oh = req & (~req + NREQ'(1));
  assign w_oh = |w_hi ? w_hi_oh : w_lo_oh;
  for (genvar b = 0; b < OW; b++) begin : g_enc
    for (genvar g = 0; g < NREQ; g++) begin : g_bit
      assign w_bit[b][g] = (((g >> b) & 1) != 0) ? w_oh[g] : 1'b0;
    end
    assign w_sel[b] = |w_bit[b];
  end
  assign w_any = |req;
  assign w_done = alu_done && (r_cnt != 8'd0);
  assign w_to = r_cnt == 8'(TIMEOUT - 1);
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_nxt = S_ISSUE;
      S_ISSUE: w_nxt = S_WAIT;
      S_WAIT:  if (w_done || w_to) w_nxt = S_RESP;
      default: w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) r_state <= S_IDLE;
    else r_state <= w_nxt;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ptr <= OW'(NREQ - 1);
      r_owner <= '0;
      r_cnt <= '0;
      r_ack <= '0;
      r_rsp_valid <= '0;
      r_res <= '0;
      r_err <= 1'b0;
      r_opa <= '0;
      r_opb <= '0;
      r_opc <= '0;
      r_en <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_ack <= '0;
      r_rsp_valid <= '0;
      r_en <= 1'b0;
      r_busy <= w_nxt != S_IDLE;
      if (r_state == S_IDLE && w_any) begin
        r_opa <= req_opA[16*w_sel +: 16];
        r_opb <= req_opB[16*w_sel +: 16];
        r_opc <= req_opcode[2*w_sel +: 2];
        r_owner <= w_sel;
        r_ack <= w_oh;
        r_en <= 1'b1;
      end
      if (r_state == S_ISSUE) r_cnt <= '0;
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_done) begin
          r_res <= alu_res;
          r_err <= 1'b0;
        end else if (w_to) begin
          r_res <= '0;
          r_err <= 1'b1;
        end
        if (w_done || w_to) r_rsp_valid <= NREQ'(1) << r_owner;
      end
      if (r_state == S_RESP) r_ptr <= r_owner;
    end
  end
  assign ack = r_ack;
  assign rsp_valid = r_rsp_valid;
  assign rsp_res = r_res;
  assign rsp_err = r_err;
  assign alu_opA = r_opa;
  assign alu_opB = r_opb;
  assign alu_opcode = r_opc;
  assign alu_en = r_en;
  assign busy = r_busy;
  assign owner = r_owner;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed tests of alu_arbiter against a behavioural ALU stub.
module tb_alu_arbiter;
  logic clk = 1'b0, nrst = 1'b0;
  logic [3:0] req = '0;
  logic [63:0] req_opA = '0, req_opB = '0;
  logic [7:0] req_opcode = '0;
  logic [3:0] ack, rsp_valid;
  logic [31:0] rsp_res;
  logic rsp_err;
  logic [15:0] alu_opA, alu_opB;
  logic [1:0] alu_opcode, owner;
  logic alu_en, busy;
  logic [31:0] alu_res = '0;
  logic alu_done = 1'b0;
  int total = 0, bad = 0;
  int a_lat = 1, a_cnt = 0;
  logic a_hang = 1'b0, a_stale = 1'b0, a_clr = 1'b0;
  logic [31:0] a_val = '0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(4), .TIMEOUT(63)) dut (
    .clk(clk), .nrst(nrst), .req(req), .req_opA(req_opA), .req_opB(req_opB),
    .req_opcode(req_opcode), .ack(ack), .rsp_valid(rsp_valid), .rsp_res(rsp_res),
    .rsp_err(rsp_err), .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode),
    .alu_en(alu_en), .alu_res(alu_res), .alu_done(alu_done), .busy(busy), .owner(owner)
  );

  function automatic logic [31:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    logic signed [31:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'd0: return sa + sb;
      2'd1: return sa * sb;
      2'd2: return (sb == 0) ? 32'hFFFF_FFFF : sa / sb;
      default: return {31'd0, sa > sb};
    endcase
  endfunction

  // ALU stub: done is a level held until the next en; stale mode clears it one cycle late.
  always @(posedge clk) begin
    if (alu_en) begin
      a_cnt <= a_lat;
      a_val <= alu_f(alu_opA, alu_opB, alu_opcode);
      if (!a_stale) alu_done <= 1'b0;
      a_clr <= a_stale;
    end else begin
      a_clr <= 1'b0;
      if (a_cnt == 1 && !a_hang) begin
        alu_done <= 1'b1;
        alu_res <= a_val;
      end else if (a_clr) alu_done <= 1'b0;
      if (a_cnt > 0) a_cnt <= a_cnt - 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    req_opA[16*i +: 16] = a;
    req_opB[16*i +: 16] = b;
    req_opcode[2*i +: 2] = op;
  endtask

  task automatic wait_ack(input int i, output int n);
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      tick;
      if (ack[i]) begin
        n = k;
        return;
      end
    end
  endtask

  task automatic wait_any(output int n);
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      tick;
      if (|ack) begin
        n = k;
        return;
      end
    end
  endtask

  task automatic wait_rsp(input int i, output int n);
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      tick;
      if (rsp_valid[i]) begin
        n = k;
        return;
      end
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    tick;
    tick;
    total++; if ({ack, rsp_valid, busy, owner, alu_en} !== 12'd0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", {ack, rsp_valid, busy, owner, alu_en}); end
    total++; if ({alu_opA, alu_opB, alu_opcode} !== 34'd0) begin bad++; $display("FAIL reset_alu_ops got=%h want=0", {alu_opA, alu_opB, alu_opcode}); end
    total++; if ({rsp_res, rsp_err} !== 33'd0) begin bad++; $display("FAIL reset_rsp got=%h want=0", {rsp_res, rsp_err}); end
    nrst = 1'b1;
    tick;
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_round_robin;
    int n, m;
    a_lat = 1;
    for (int i = 0; i < 4; i++) set_op(i, 16'(10 * i), 16'(i + 1), 2'b00);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_any(n);
      total++; if (n < 0 || ack !== (4'b0001 << k)) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", k, ack, 4'b0001 << k); end
      req[owner] = 1'b0;
      wait_rsp(k, m);
      total++; if (m < 0 || rsp_res !== 32'(11 * k + 1)) begin bad++; $display("FAIL rr_res%0d got=%0d want=%0d", k, rsp_res, 11 * k + 1); end
    end
    req = 4'b1001;
    wait_any(n);
    total++; if (n < 0 || ack !== 4'b0001) begin bad++; $display("FAIL rr_wrap got=%b want=0001", ack); end
    req[0] = 1'b0;
    wait_rsp(0, m);
    wait_ack(3, n);
    total++; if (n < 0) begin bad++; $display("FAIL rr_second got=timeout want=ack3"); end
    req[3] = 1'b0;
    wait_rsp(3, m);
    total++; if (m < 0 || rsp_res !== 32'd34) begin bad++; $display("FAIL rr_res3b got=%0d want=34", rsp_res); end
  endtask

  task automatic test_add;
    int n, m;
    a_lat = 1;
    tick;
    set_op(0, 16'd111, 16'd135, 2'b00);
    req[0] = 1'b1;
    tick;
    total++; if ({ack, alu_en, busy, owner} !== 8'b0001_1_1_00) begin bad++; $display("FAIL add_issue got=%b want=00011100", {ack, alu_en, busy, owner}); end
    req[0] = 1'b0;
    tick;
    total++; if ({ack, alu_en} !== 5'd0) begin bad++; $display("FAIL add_en_width got=%b want=00000", {ack, alu_en}); end
    tick;
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL add_early got=%b want=0000", rsp_valid); end
    tick;
    total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL add_lat4 got=%b want=0001", rsp_valid); end
    total++; if ({rsp_res, rsp_err} !== {32'd246, 1'b0}) begin bad++; $display("FAIL add_res got=%0d err=%b want=246 err=0", rsp_res, rsp_err); end
    tick;
    set_op(0, 16'hFF91, 16'd135, 2'b00);
    req[0] = 1'b1;
    wait_ack(0, n);
    req[0] = 1'b0;
    wait_rsp(0, m);
    total++; if (n != 1 || m != 3 || rsp_res !== 32'd24) begin bad++; $display("FAIL add_neg got=%0d n=%0d m=%0d want=24 n=1 m=3", rsp_res, n, m); end
  endtask

  task automatic test_mult;
    int n;
    logic stable, seen;
    a_lat = 4;
    stable = 1'b1;
    seen = 1'b0;
    tick;
    set_op(2, 16'd135, 16'hFF91, 2'b01);
    req[2] = 1'b1;
    wait_ack(2, n);
    total++; if (n < 0 || {alu_opcode, alu_opB} !== {2'b01, 16'hFF91}) begin bad++; $display("FAIL mult_latch got=%h want=1ff91", {alu_opcode, alu_opB}); end
    req[2] = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      tick;
      if (alu_opA !== 16'd135) stable = 1'b0;
      seen = rsp_valid[2];
    end
    total++; if (!stable) begin bad++; $display("FAIL mult_opA_stable got=changed want=135"); end
    total++; if (!seen || rsp_valid !== 4'b0100) begin bad++; $display("FAIL mult_valid got=%b want=0100", rsp_valid); end
    total++; if ({rsp_res, rsp_err} !== {32'hFFFF_C577, 1'b0}) begin bad++; $display("FAIL mult_res got=%h err=%b want=ffffc577 err=0", rsp_res, rsp_err); end
  endtask

  task automatic test_watchdog;
    int n, m;
    a_hang = 1'b1;
    tick;
    set_op(1, 16'd7, 16'd8, 2'b00);
    req[1] = 1'b1;
    tick;
    total++; if (ack !== 4'b0010) begin bad++; $display("FAIL wd_ack got=%b want=0010", ack); end
    req[1] = 1'b0;
    wait_rsp(1, m);
    total++; if (m + 1 != 65) begin bad++; $display("FAIL wd_latency got=%0d want=65", m + 1); end
    total++; if ({rsp_res, rsp_err} !== {32'd0, 1'b1}) begin bad++; $display("FAIL wd_err got=%h err=%b want=0 err=1", rsp_res, rsp_err); end
    a_hang = 1'b0;
    a_lat = 2;
    tick;
    set_op(3, 16'd7, 16'd8, 2'b00);
    req[3] = 1'b1;
    wait_ack(3, n);
    req[3] = 1'b0;
    wait_rsp(3, m);
    total++; if (n != 1 || m < 0 || {rsp_res, rsp_err} !== {32'd15, 1'b0}) begin bad++; $display("FAIL wd_recover got=%0d err=%b n=%0d want=15 err=0 n=1", rsp_res, rsp_err, n); end
  endtask

  task automatic test_stale_done;
    int n, m;
    a_stale = 1'b1;
    a_lat = 3;
    tick;
    set_op(0, 16'd1000, 16'd2000, 2'b00);
    req[0] = 1'b1;
    wait_ack(0, n);
    req[0] = 1'b0;
    wait_rsp(0, m);
    total++; if (m != 5) begin bad++; $display("FAIL stale_latency got=%0d want=5", m); end
    total++; if ({rsp_res, rsp_err} !== {32'd3000, 1'b0}) begin bad++; $display("FAIL stale_res got=%0d err=%b want=3000 err=0", rsp_res, rsp_err); end
    a_stale = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n, m;
    logic seen;
    seen = 1'b0;
    a_lat = 10;
    tick;
    set_op(1, 16'd100, 16'd7, 2'b10);
    req[1] = 1'b1;
    wait_ack(1, n);
    req[1] = 1'b0;
    tick;
    tick;
    #2 nrst = 1'b0;
    #1;
    total++; if ({ack, rsp_valid, busy, owner, alu_en} !== 12'd0) begin bad++; $display("FAIL rmid_ctrl got=%h want=0", {ack, rsp_valid, busy, owner, alu_en}); end
    total++; if ({alu_opA, alu_opB, alu_opcode, rsp_res, rsp_err} !== 67'd0) begin bad++; $display("FAIL rmid_data got=%h want=0", {alu_opA, alu_opB, alu_opcode, rsp_res, rsp_err}); end
    for (int k = 0; k < 3; k++) begin
      tick;
      if (rsp_valid !== 4'b0000) seen = 1'b1;
    end
    nrst = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick;
      if (rsp_valid !== 4'b0000) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL rmid_no_rsp got=rsp_valid want=none"); end
    a_lat = 1;
    set_op(0, 16'd1, 16'd2, 2'b00);
    set_op(1, 16'd3, 16'd4, 2'b00);
    req = 4'b0011;
    wait_any(n);
    total++; if (n < 0 || ack !== 4'b0001) begin bad++; $display("FAIL rmid_ptr got=%b want=0001", ack); end
    req[0] = 1'b0;
    wait_rsp(0, m);
    wait_ack(1, n);
    req[1] = 1'b0;
    wait_rsp(1, m);
    total++; if (n < 0 || m < 0 || rsp_res !== 32'd7) begin bad++; $display("FAIL rmid_req1 got=%0d want=7", rsp_res); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=hang want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_round_robin;
    test_add;
    test_mult;
    test_watchdog;
    test_stale_done;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one sequential ALU (add, mult, div, compare) among `NREQ` requesters. It accepts a request with operands, issues a single-cycle `en` pulse to the ALU, and waits for `done`. It then returns the 32-bit result to the granted requester, with a watchdog that ends any operation whose `done` never arrives. It sits between the requester blocks and the ALU instance; the ALU ports connect directly to the `alu_*` ports.

## Interface
- `NREQ`, 4: number of requesters; 2..8.
- `TIMEOUT`, 63: maximum WAIT cycles before an error response; 2..255.
- `clk` in 1: single clock, rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `req` in NREQ: per-requester request level.
- `req_opA` in 16*NREQ: operand A of requester i, in bits [16i+15:16i].
- `req_opB` in 16*NREQ: operand B of requester i, same packing as `req_opA`.
- `req_opcode` in 2*NREQ: opcode of requester i: 00 add, 01 mult, 10 div, 11 compare.
- `ack` out NREQ: one-cycle pulse; request i accepted and operands latched.
- `rsp_valid` out NREQ: one-cycle pulse; response for requester i on `rsp_res`/`rsp_err`.
- `rsp_res` out 32: result, valid with `rsp_valid`.
- `rsp_err` out 1: watchdog expired, valid with `rsp_valid`.
- `alu_opA` out 16: latched operand A to the ALU.
- `alu_opB` out 16: latched operand B to the ALU.
- `alu_opcode` out 2: latched opcode to the ALU.
- `alu_en` out 1: ALU start pulse.
- `alu_res` in 32: ALU result.
- `alu_done` in 1: ALU completion.
- `busy` out 1: high in every state except IDLE.
- `owner` out clog2(NREQ): index of the current grant.

## Operation
- State machine IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered.
- **IDLE**
  - If any `req` is high: select the first high bit searching from `ptr+1` upward, wrapping modulo NREQ.
  - Latch that requester's opA, opB and opcode into the `alu_*` registers, set `owner`, go to ISSUE.
  - If no `req` is high, stay in IDLE.
- **ISSUE** (one cycle): `alu_en`=1 and `ack[owner]`=1. Clear the watchdog counter. Go to WAIT.
- **WAIT**
  - The counter increments every cycle.
  - `alu_done` is ignored in the first WAIT cycle (blanking: the ALU clears a stale `done` only after sampling `en`).
  - From the second WAIT cycle on, `alu_done`=1 captures `alu_res` into `rsp_res`, clears `rsp_err` and goes to RESP.
  - If the counter reaches TIMEOUT without `done`: `rsp_res`=0, `rsp_err`=1, go to RESP.
  - If `done` and the timeout occur in the same cycle, `done` wins.
- **RESP** (one cycle): `rsp_valid[owner]`=1, `ptr`<=`owner`, go to IDLE.
- `alu_opA`, `alu_opB` and `alu_opcode` stay stable from ISSUE through RESP. They change only on the next grant.
- Requester contract:
  - Hold `req` and operands until `ack`.
  - Dropping `req` before `ack` withdraws the request; a request already latched in IDLE still completes.
  - `req` must be low by the cycle after `ack`, otherwise it is re-arbitrated as a new request.
- Fairness: a requester re-requesting immediately after its response has lowest priority in the next arbitration.
- No width conversion is applied: `alu_res` is passed through unmodified, including sign.
- Reset (asynchronous, any state, including mid-WAIT):
  - State returns to IDLE, `ptr`=NREQ-1 (requester 0 has first priority), counter=0.
  - `ack`, `rsp_valid`, `rsp_res`, `rsp_err`, `alu_en`, `alu_opA`, `alu_opB`, `alu_opcode`, `busy` and `owner` all go to 0.
  - An in-flight operation is discarded with no response.

## Timing
- Cycle 0: `req` sampled in IDLE.
- Cycle 1: ISSUE, with `ack` and `alu_en` high.
- Cycle 2 onward: WAIT.
- The cycle after `done` is observed is RESP.
- Minimum request-to-`rsp_valid` latency is 4 cycles: `done` first honoured in cycle 3, RESP in cycle 4.
- Back-to-back throughput: one operation per (ALU latency + 3) cycles minimum.
- Timeout response arrives TIMEOUT+2 cycles after the request is sampled.
- `alu_en` is never high outside ISSUE and is exactly one cycle wide.

## Test plan
- **Add:** req0 with add, 111 + 135 -> `ack[0]` in cycle 1, `rsp_valid[0]` with `rsp_res`=246 and `rsp_err`=0. A second op, -111 + 135 -> `rsp_res`=24.
- **Round-robin:** `req`=4'b1111 held, each requester dropping its `req` after its `ack` -> grant order 0,1,2,3. Then req0 and req3 re-raise with `ptr`=3 -> req0 is granted first.
- **Signed mult:** req2 with mult, 135 × -111 (opB=16'hFF91) -> `rsp_valid[2]` with `rsp_res`=32'hFFFFC577. `alu_opA` stays stable throughout WAIT.
- **Watchdog:** ALU stub with `alu_done` tied low, TIMEOUT=63 -> `rsp_valid[1]`, `rsp_err`=1, `rsp_res`=0, 65 cycles after the request is sampled. The arbiter then returns to IDLE and grants the next request.
- **Stale done:** ALU stub holding `done` high through ISSUE and the first WAIT cycle, then completing -> the stale `done` is ignored and the real result is returned.
- **Reset mid-operation:** `nrst` low during WAIT of a div -> all outputs go to 0 immediately and no `rsp_valid` is produced. After release, req1 is granted with `ptr` reset, i.e. req0 would win if both are pending.
